traffic_phase_scheduler: RTL

//  Demand-driven phase sequencer for a 4-approach intersection; supersedes the fixed round-robin light rotation.

---
 rtl/traffic_pkg.sv | 28 ++
 rtl/traffic_phase_scheduler_if.sv | 22 ++
 rtl/rr_next_approach.sv | 25 ++
 rtl/traffic_phase_scheduler.sv | 122 ++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types for the traffic phase scheduler: phase states and approach codes.
package traffic_pkg;

  typedef enum logic [1:0] {
    ALLRED_IDLE = 2'd0,
    GREEN       = 2'd1,
    YELLOW      = 2'd2,
    ALLRED      = 2'd3
  } state_t;

  localparam logic [1:0] N = 2'd0;
  localparam logic [1:0] E = 2'd1;
  localparam logic [1:0] S = 2'd2;
  localparam logic [1:0] W = 2'd3;

  function automatic logic [3:0] dirOneHot(input logic [1:0] dir);
    logic [3:0] oneHot;
    case (dir)
      N:       oneHot = 4'b0001;
      E:       oneHot = 4'b0010;
      S:       oneHot = 4'b0100;
      W:       oneHot = 4'b1000;
      default: oneHot = 4'b0000;
    endcase
    return oneHot;
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Demand, preemption and lamp signals between the scheduler and its surroundings.
interface traffic_phase_scheduler_if;
  logic       tick;
  logic [3:0] req;
  logic       emerg;
  logic [1:0] emerg_dir;
  logic [3:0] green;
  logic [3:0] yellow;
  logic [3:0] red;
  logic [1:0] cur_dir;
  logic       emerg_ack;

  modport master (
    output tick, req, emerg, emerg_dir,
    input  green, yellow, red, cur_dir, emerg_ack
  );

  modport slave (
    input  tick, req, emerg, emerg_dir,
    output green, yellow, red, cur_dir, emerg_ack
  );
endinterface

// File: rtl/rr_next_approach.sv
// Combinational round-robin picker: first pending approach after cur_dir, wrapping to cur_dir last.
module rr_next_approach
  import traffic_pkg::*;
(
  input  logic [3:0] i_pending,
  input  logic [1:0] i_cur_dir,
  output logic [1:0] o_nxt,
  output logic       o_any
);

  logic [1:0] w_idx;

  // Walk the search order backwards so the closest pending approach is the last write.
  always_comb begin
    o_nxt = i_cur_dir;
    w_idx = i_cur_dir;
    for (int k = 4; k >= 1; k--) begin
      w_idx = i_cur_dir + 2'(k);
      if (i_pending[w_idx]) o_nxt = w_idx;
    end
  end

  assign o_any = |i_pending;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven 4-approach phase sequencer with adaptive green, yellow/all-red clearance and preemption.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN = 5,
  parameter int GREEN_MAX = 30,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int CNT_W     = 8
)(
  input logic                       clk,
  input logic                       rst,
  traffic_phase_scheduler_if.slave  bus
);

  localparam logic [CNT_W:0] L_GMIN = (CNT_W+1)'(GREEN_MIN);
  localparam logic [CNT_W:0] L_GMAX = (CNT_W+1)'(GREEN_MAX);
  localparam logic [CNT_W:0] L_YT   = (CNT_W+1)'(YELLOW_T);
  localparam logic [CNT_W:0] L_ART  = (CNT_W+1)'(ALLRED_T);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_pending;
  logic [1:0]       r_curDir;

  logic [1:0]       w_rrNxt;
  logic             w_rrAny;
  logic [1:0]       w_nxt;
  logic             w_others;
  logic             w_demand;
  logic             w_enterGreen;
  logic [CNT_W:0]   w_cntPlus;
  logic [CNT_W-1:0] w_cntSat;
  logic             w_cutGreen;
  logic [3:0]       w_green;
  logic [3:0]       w_yellow;

  rr_next_approach u_rr (
    .i_pending (r_pending),
    .i_cur_dir (r_curDir),
    .o_nxt     (w_rrNxt),
    .o_any     (w_rrAny)
  );

  assign w_nxt     = bus.emerg ? bus.emerg_dir : w_rrNxt;
  assign w_others  = |(r_pending & ~dirOneHot(r_curDir));
  assign w_demand  = bus.emerg | w_rrAny;
  assign w_cntPlus = {1'b0, r_cnt} + 1'b1;
  assign w_cntSat  = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

  // Gap-out needs the minimum served and the owner idle; max-out only needs a competitor.
  assign w_cutGreen = bus.tick && !bus.emerg && w_others &&
                      ((w_cntPlus >= L_GMIN && !bus.req[r_curDir]) || w_cntPlus >= L_GMAX);

  assign w_enterGreen = w_demand &&
                        ((r_state == ALLRED_IDLE) ||
                         (r_state == ALLRED && bus.tick && w_cntPlus == L_ART));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ALLRED_IDLE;
      r_cnt     <= '0;
      r_pending <= 4'b0000;
      r_curDir  <= W;
    end else if (w_enterGreen) begin
      r_state   <= GREEN;
      r_cnt     <= '0;
      r_curDir  <= w_nxt;
      r_pending <= (r_pending & ~dirOneHot(w_nxt)) | bus.req;
    end else begin
      r_pending <= r_pending | bus.req;
      case (r_state)
        ALLRED_IDLE: r_cnt <= '0;
        GREEN: begin
          if (bus.emerg && bus.emerg_dir != r_curDir) begin
            r_state <= YELLOW;
            r_cnt   <= '0;
          end else if (w_cutGreen) begin
            r_state <= YELLOW;
            r_cnt   <= '0;
          end else if (bus.tick) begin
            r_cnt <= w_cntSat;
          end
        end
        YELLOW: begin
          if (bus.tick) begin
            if (w_cntPlus == L_YT) begin
              r_state <= ALLRED;
              r_cnt   <= '0;
            end else begin
              r_cnt <= w_cntSat;
            end
          end
        end
        ALLRED: begin
          // Reaching here on the final tick means nobody wants the phase.
          if (bus.tick) begin
            if (w_cntPlus == L_ART) begin
              r_state <= ALLRED_IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= w_cntSat;
            end
          end
        end
        default: begin
          r_state <= ALLRED_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign w_green       = (r_state == GREEN)  ? dirOneHot(r_curDir) : 4'b0000;
  assign w_yellow      = (r_state == YELLOW) ? dirOneHot(r_curDir) : 4'b0000;
  assign bus.green     = w_green;
  assign bus.yellow    = w_yellow;
  assign bus.red       = ~(w_green | w_yellow);
  assign bus.cur_dir   = r_curDir;
  assign bus.emerg_ack = (r_state == GREEN) && bus.emerg && (bus.emerg_dir == r_curDir);

endmodule
